// File: rtl/iosram_wr_drain_pkg.sv
// Shared types and sizing for the IO SRAM write-drain path.
//   drain_state_e : drain FSM states (IDLE, SEND)
//   io_word_t     : {addr, data} word layout at the default widths
//   BEATS / BW    : beats per word and beat-index width at the default widths
//   beats_of / beat_idx_w : the same derivations for any parameterisation
package iosram_wr_drain_pkg;

  localparam int unsigned IO_ADDR_WIDTH_DEF = 16;
  localparam int unsigned IO_DATA_WIDTH_DEF = 256;
  localparam int unsigned BEAT_WIDTH_DEF    = 32;
  localparam int unsigned FIFO_DEPTH_DEF    = 4;

  function automatic int unsigned beats_of(input int unsigned dw, input int unsigned bw);
    return dw / bw;
  endfunction

  // A single-beat word still needs one index bit so bus_addr never has a zero-width slice.
  function automatic int unsigned beat_idx_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int unsigned BEATS = beats_of(IO_DATA_WIDTH_DEF, BEAT_WIDTH_DEF);
  localparam int unsigned BW    = beat_idx_w(BEATS);

  typedef enum logic {IDLE, SEND} drain_state_e;

  typedef struct packed {
    logic [IO_ADDR_WIDTH_DEF-1:0] addr;
    logic [IO_DATA_WIDTH_DEF-1:0] data;
  } io_word_t;

endpackage

// File: rtl/iosram_wr_drain_fifo.sv
// Synchronous FIFO holding buffered IO words.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push_i     : write wdata_i at the tail (caller guarantees room or a same-cycle pop)
//   pop_i      : retire the head entry (ignored when empty)
//   wdata_i    : word to write
//   rdata_o    : current head entry
//   full_o, empty_o, count_o : occupancy status
// Pointers carry one extra wrap bit so full and empty differ only in the MSB.
module iosram_wr_drain_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned PW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic             do_pop;

  assign do_pop = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (do_pop) rd_q <= rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;

endmodule

// File: rtl/iosram_wr_drain.sv
// Drains the IO-write word stream onto a valid/ready beat bus.
//   clk, rst                : clock, asynchronous active-high reset
//   io_en_in/addr_in/data_in: incoming words, no backpressure
//   bus_valid/bus_ready     : beat handshake
//   bus_addr                : {word addr, beat index}
//   bus_data                : beat payload, LSB slice of the word first
//   bus_last                : final beat of a word
//   overflow                : sticky, a word arrived while the FIFO was full
//   busy                    : FIFO non-empty or a word is being sent
// Optional feature macro IOSRAM_WR_DRAIN_STATS_EN adds stat_words (drained
// words) and stat_drops (dropped words, saturating).
module iosram_wr_drain
  import iosram_wr_drain_pkg::*;
#(
  parameter int unsigned IO_ADDR_WIDTH = IO_ADDR_WIDTH_DEF,
  parameter int unsigned IO_DATA_WIDTH = IO_DATA_WIDTH_DEF,
  parameter int unsigned BEAT_WIDTH    = BEAT_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF,
  localparam int unsigned WB           = beat_idx_w(beats_of(IO_DATA_WIDTH, BEAT_WIDTH))
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        io_en_in,
  input  logic [IO_ADDR_WIDTH-1:0]    io_addr_in,
  input  logic [IO_DATA_WIDTH-1:0]    io_data_in,
  output logic                        bus_valid,
  input  logic                        bus_ready,
  output logic [IO_ADDR_WIDTH+WB-1:0] bus_addr,
  output logic [BEAT_WIDTH-1:0]       bus_data,
  output logic                        bus_last,
  output logic                        overflow,
  output logic                        busy
`ifdef IOSRAM_WR_DRAIN_STATS_EN
  ,
  output logic [31:0]                 stat_words,
  output logic [15:0]                 stat_drops
`endif
);

  localparam int unsigned NBEATS    = beats_of(IO_DATA_WIDTH, BEAT_WIDTH);
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WB-1:0] LAST_BEAT = WB'(NBEATS - 1);

  typedef struct packed {
    logic [IO_ADDR_WIDTH-1:0] addr;
    logic [IO_DATA_WIDTH-1:0] data;
  } word_t;

  word_t        wr_word;
  word_t        head;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CW-1:0] fifo_count;
  logic         drop;
  logic         on_last;

  drain_state_e  state_q, state_d;
  logic [WB-1:0] beat_q, beat_d;
  logic          overflow_q;

  assign wr_word = '{addr: io_addr_in, data: io_data_in};

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign fifo_push = io_en_in & (~fifo_full | fifo_pop);
  assign drop      = io_en_in & fifo_full & ~fifo_pop;

  iosram_wr_drain_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (wr_word),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign on_last = (beat_q == LAST_BEAT);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    fifo_pop  = 1'b0;
    bus_valid = 1'b0;
    bus_last  = 1'b0;
    bus_addr  = '0;
    bus_data  = '0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = SEND;
          beat_d  = '0;
        end
      end
      SEND: begin
        bus_valid = 1'b1;
        bus_last  = on_last;
        bus_addr  = {head.addr, beat_q};
        bus_data  = head.data[beat_q*BEAT_WIDTH +: BEAT_WIDTH];
        if (bus_ready) begin
          if (on_last) begin
            fifo_pop = 1'b1;
            beat_d   = '0;
            // A word pushed alongside the final pop keeps the stream bubble-free.
            if (fifo_count == CW'(1) && !io_en_in) state_d = IDLE;
          end else begin
            beat_d = beat_q + WB'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
  assign busy     = (fifo_count != '0) | (state_q == SEND);

`ifdef IOSRAM_WR_DRAIN_STATS_EN
  logic [31:0] words_q;
  logic [15:0] drops_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_q <= '0;
      drops_q <= '0;
    end else begin
      if (fifo_pop) words_q <= words_q + 32'd1;
      if (drop && drops_q != '1) drops_q <= drops_q + 16'd1;
    end
  end

  assign stat_words = words_q;
  assign stat_drops = drops_q;
`endif

endmodule

// File: tb/tb_iosram_wr_drain.sv
module tb_iosram_wr_drain;
  import iosram_wr_drain_pkg::*;

  localparam int NB    = BEATS;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         io_en_in;
  logic [15:0]  io_addr_in;
  logic [255:0] io_data_in;
  logic         bus_valid;
  logic         bus_ready;
  logic [18:0]  bus_addr;
  logic [31:0]  bus_data;
  logic         bus_last;
  logic         overflow;
  logic         busy;
`ifdef IOSRAM_WR_DRAIN_STATS_EN
  logic [31:0]  stat_words;
  logic [15:0]  stat_drops;
`endif

  always #5 clk = ~clk;

  iosram_wr_drain #(
    .IO_ADDR_WIDTH (16),
    .IO_DATA_WIDTH (256),
    .BEAT_WIDTH    (32),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .io_en_in   (io_en_in),
    .io_addr_in (io_addr_in),
    .io_data_in (io_data_in),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .bus_last   (bus_last),
    .overflow   (overflow),
    .busy       (busy)
`ifdef IOSRAM_WR_DRAIN_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_drops (stat_drops)
`endif
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0]  a;
    logic [255:0] d;
  } w_t;

  // Reference model: queue of buffered words, whether a word is on the bus,
  // which beat of it is shown, and the sticky/statistics values.
  w_t m_q[$];
  bit m_act;
  int m_beat;
  bit m_ovf;
  int m_words;
  int m_drops;

  logic [18:0] log_a[$];
  logic [31:0] log_d[$];
  bit          log_l[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_act   = 1'b0;
    m_beat  = 0;
    m_ovf   = 1'b0;
    m_words = 0;
    m_drops = 0;
  endtask

  // Applies one clock edge's worth of the rules to the model.
  task automatic model_step();
    int sz0;
    bit hs, pop, acc;
    if (rst) begin
      model_reset();
      return;
    end
    sz0 = m_q.size();
    hs  = m_act && bus_ready;
    pop = hs && (m_beat == NB - 1);
    acc = 1'b0;
    if (io_en_in) begin
      if (sz0 < DEPTH || pop) acc = 1'b1;
      else begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (pop) begin
      void'(m_q.pop_front());
      m_words++;
      m_beat = 0;
    end else if (hs) begin
      m_beat++;
    end
    if (acc) m_q.push_back('{a: io_addr_in, d: io_data_in});
    if (m_act) m_act = (m_q.size() != 0);
    else       m_act = (sz0 != 0);
  endtask

  task automatic compare_all();
    logic [18:0] ea;
    logic [31:0] ed;
    bit          el;
    w_t          h;
    ea = '0; ed = '0; el = 1'b0;
    if (m_act) begin
      h  = m_q[0];
      ea = {h.a, 3'(m_beat)};
      ed = h.d[m_beat*32 +: 32];
      el = (m_beat == NB - 1);
    end
    chk("bus_valid", bus_valid, m_act);
    chk("bus_addr", bus_addr, ea);
    chk("bus_data", bus_data, ed);
    chk("bus_last", bus_last, el);
    chk("busy", busy, (m_act || m_q.size() != 0));
    chk("overflow", overflow, m_ovf);
`ifdef IOSRAM_WR_DRAIN_STATS_EN
    chk("stat_words", stat_words, 64'(m_words));
    chk("stat_drops", stat_drops, 64'(m_drops));
`endif
  endtask

  // One clock: drive at the falling edge, model the rising edge, compare at the next falling edge.
  task automatic cycle(input bit en, input logic [15:0] a, input logic [255:0] d, input bit rdy);
    io_en_in   = en;
    io_addr_in = a;
    io_data_in = d;
    bus_ready  = rdy;
    #1;
    if (bus_valid && rdy) begin
      log_a.push_back(bus_addr);
      log_d.push_back(bus_data);
      log_l.push_back(bus_last);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [255:0] mkword(input int tag);
    logic [255:0] r;
    for (int j = 0; j < NB; j++) r[j*32 +: 32] = 32'((tag << 8) | j);
    return r;
  endfunction

  function automatic logic [255:0] rndword();
    logic [255:0] r;
    for (int j = 0; j < NB; j++) r[j*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
    log_l.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(0, '0, '0, 0);
    cycle(0, '0, '0, 0);
    rst = 1'b0;
    cycle(0, '0, '0, 0);
    clear_log();
  endtask

  task automatic wait_idle(input int maxc, input bit toggle);
    int n;
    n = 0;
    while ((m_act || m_q.size() != 0) && n < maxc) begin
      cycle(0, '0, '0, toggle ? bit'(n % 2 == 0) : 1'b1);
      n++;
    end
    chk("drain_idle", busy, 0);
  endtask

  initial begin
    bit          done;
    bit          en;
    bit          rdy;
    int          n;
    logic [31:0] prev_d;
    logic [18:0] prev_a;
    bit          stalled;

    rst        = 1'b1;
    io_en_in   = 1'b0;
    io_addr_in = '0;
    io_data_in = '0;
    bus_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset state, literal.
    chk("rst_valid", bus_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_data", bus_data, 0);

    // 1: single word, ready held high.
    cycle(1, 16'h0010, mkword(0), 1);
    chk("lat_idle", bus_valid, 0);
    cycle(0, '0, '0, 1);
    chk("lat_first", bus_valid, 1);
    chk("lat_addr", bus_addr, 19'h00080);
    wait_idle(50, 0);
    chk("s1_beats", log_a.size(), 8);
    for (int i = 0; i < 8 && i < log_a.size(); i++) begin
      chk("s1_addr", log_a[i], 19'h00080 + 19'(i));
      chk("s1_data", log_d[i], 32'(i));
      chk("s1_last", log_l[i], (i == 7));
    end

    // 2: same word, ready toggling; outputs must hold across stalls.
    do_reset();
    cycle(1, 16'h0010, mkword(0), 0);
    stalled = 1'b0;
    prev_a  = '0;
    prev_d  = '0;
    n = 0;
    while ((m_act || m_q.size() != 0) && n < 60) begin
      rdy = bit'(n % 2);
      if (stalled) begin
        chk("s2_hold_addr", bus_addr, prev_a);
        chk("s2_hold_data", bus_data, prev_d);
      end
      stalled = bus_valid && !rdy;
      prev_a  = bus_addr;
      prev_d  = bus_data;
      cycle(0, '0, '0, rdy);
      n++;
    end
    chk("drain_idle", busy, 0);
    chk("s2_beats", log_a.size(), 8);
    for (int i = 0; i < 8 && i < log_d.size(); i++) chk("s2_order", log_d[i], 32'(i));

    // 3: five words with the bus stalled; the fifth is dropped.
    do_reset();
    for (int i = 1; i <= 5; i++) cycle(1, 16'(i), mkword(i), 0);
    chk("s3_ovf", overflow, 1);
    chk("s3_busy", busy, 1);
    wait_idle(100, 0);
    chk("s3_beats", log_a.size(), 32);
    for (int j = 0; j < 32 && j < log_a.size(); j++) begin
      chk("s3_addr", log_a[j], {16'(j / 8 + 1), 3'(j % 8)});
      chk("s3_data", log_d[j], 32'(((j / 8 + 1) << 8) | (j % 8)));
    end
`ifdef IOSRAM_WR_DRAIN_STATS_EN
    chk("s6_words", stat_words, 4);
    chk("s6_drops", stat_drops, 1);
`endif

    // 4: push on a full FIFO coincident with the last-beat handshake.
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, 16'(i), mkword(i), 0);
    done = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      en = m_act && (m_beat == NB - 1) && (m_q.size() == DEPTH);
      cycle(en, 16'h00AA, mkword(8'hAA), 1);
      if (en) begin
        done = 1'b1;
        chk("s4_ovf", overflow, 0);
        chk("s4_valid", bus_valid, 1);
        chk("s4_next", bus_addr, {16'h0002, 3'd0});
      end
      n++;
    end
    chk("s4_reached", done, 1);
    wait_idle(100, 0);
    chk("s4_beats", log_a.size(), 40);
    if (log_a.size() == 40) chk("s4_tail", log_a[39], {16'h00AA, 3'd7});

    // 5: reset during beat 3 aborts the word.
    do_reset();
    cycle(1, 16'h0033, mkword(3), 1);
    n = 0;
    while (!(m_act && m_beat == 3) && n < 20) begin
      cycle(0, '0, '0, 1);
      n++;
    end
    chk("s5_at_beat3", bus_addr, {16'h0033, 3'd3});
    rst = 1'b1;
    #1;
    chk("s5_valid_now", bus_valid, 0);
    chk("s5_busy_now", busy, 0);
    model_reset();
    cycle(0, '0, '0, 1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle(0, '0, '0, 1);
    chk("s5_busy", busy, 0);
    chk("s5_ovf", overflow, 0);
    chk("s5_beats", log_a.size(), 3);

    // Randomised traffic: light load, then a congested phase that forces drops.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i >= 1000 && i < 1500) begin
        en  = ($urandom_range(0, 2) == 0);
        rdy = ($urandom_range(0, 7) == 0);
      end else begin
        en  = ($urandom_range(0, 9) == 0);
        rdy = ($urandom_range(0, 3) != 0);
      end
      cycle(en, 16'($urandom()), rndword(), rdy);
    end
    wait_idle(400, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
